// File: rtl/id_ex_stage_reg_pkg.sv
// Shared decode/execute constants and the ID/EX control-word bundle.
// Control-field encodings match the decoder's.
package id_ex_stage_reg_pkg;

   localparam logic [1:0] J_disable  = 2'b00;
   localparam logic [1:0] JumpJal    = 2'b01;
   localparam logic [1:0] JumpJalr   = 2'b10;

   localparam logic [2:0] B_disable  = 3'b000;
   localparam logic [2:0] B_type_beq = 3'b001;
   localparam logic [2:0] B_type_bne = 3'b010;
   localparam logic [2:0] B_type_blt = 3'b011;
   localparam logic [2:0] B_type_bge = 3'b100;

   localparam logic [1:0] Result_ALU = 2'b00;
   localparam logic [1:0] Result_Mem = 2'b01;
   localparam logic [1:0] Result_PC4 = 2'b10;

   localparam logic [2:0] op_add     = 3'b000;
   localparam logic [2:0] op_sub     = 3'b001;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic [1:0] jump;
      logic [2:0] branch;
      logic [2:0] alu_control;
      logic       alu_src;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '{
      valid:       1'b0,
      reg_write:   1'b0,
      result_src:  Result_ALU,
      mem_write:   1'b0,
      jump:        J_disable,
      branch:      B_disable,
      alu_control: op_add,
      alu_src:     1'b0
   };

   // An invalid slot may carry data but must never commit side effects.
   function automatic ctrl_t gate_ctrl(input ctrl_t c);
      ctrl_t r;
      r = c;
      if (!c.valid) begin
         r.reg_write = 1'b0;
         r.mem_write = 1'b0;
         r.jump      = J_disable;
         r.branch    = B_disable;
      end
      return r;
   endfunction

endpackage

// File: rtl/id_ex_stage_reg_perf_cnt.sv
// Bubble and stall counters for the ID/EX register.
// Built only when ID_EX_PERF_CNT_EN is defined.
module id_ex_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_d,
   input  logic             flush_e,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (flush_e)
            bubble_cnt <= bubble_cnt + 1'b1;
         // A flush overrides the stall, so it is not counted as one.
         if (stall_d && !flush_e)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall, flush and per-slot valid.
// Optional perf counters: define ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
`ifdef ID_EX_PERF_CNT_EN
  ,parameter int CNT_W      = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_d,
   input  logic                  flush_e,
   input  logic                  valid_d,
   input  logic                  reg_write_d,
   input  logic                  mem_write_d,
   input  logic                  alu_src_d,
   input  logic [1:0]            result_src_d,
   input  logic [1:0]            jump_d,
   input  logic [2:0]            branch_d,
   input  logic [2:0]            alu_control_d,
   input  logic [XLEN-1:0]       rd1_d,
   input  logic [XLEN-1:0]       rd2_d,
   input  logic [XLEN-1:0]       pc_d,
   input  logic [XLEN-1:0]       pc_plus4_d,
   input  logic [XLEN-1:0]       imm_ext_d,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rd_d,
   output logic                  valid_e,
   output logic                  reg_write_e,
   output logic                  mem_write_e,
   output logic                  alu_src_e,
   output logic [1:0]            result_src_e,
   output logic [1:0]            jump_e,
   output logic [2:0]            branch_e,
   output logic [2:0]            alu_control_e,
   output logic [XLEN-1:0]       rd1_e,
   output logic [XLEN-1:0]       rd2_e,
   output logic [XLEN-1:0]       pc_e,
   output logic [XLEN-1:0]       pc_plus4_e,
   output logic [XLEN-1:0]       imm_ext_e,
   output logic [REG_ADDR_W-1:0] rs1_e,
   output logic [REG_ADDR_W-1:0] rs2_e,
   output logic [REG_ADDR_W-1:0] rd_e
`ifdef ID_EX_PERF_CNT_EN
  ,output logic [CNT_W-1:0]      bubble_cnt
  ,output logic [CNT_W-1:0]      stall_cnt
`endif
);

   ctrl_t ctrl_in;
   ctrl_t ctrl_q;

   always_comb begin
      ctrl_in             = CTRL_BUBBLE;
      ctrl_in.valid       = valid_d;
      ctrl_in.reg_write   = reg_write_d;
      ctrl_in.result_src  = result_src_d;
      ctrl_in.mem_write   = mem_write_d;
      ctrl_in.jump        = jump_d;
      ctrl_in.branch      = branch_d;
      ctrl_in.alu_control = alu_control_d;
      ctrl_in.alu_src     = alu_src_d;
      ctrl_in             = gate_ctrl(ctrl_in);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ctrl_q <= CTRL_BUBBLE;
      else if (flush_e)
         ctrl_q <= CTRL_BUBBLE;
      else if (!stall_d)
         ctrl_q <= ctrl_in;
   end

   // Bubbles also clear register indices so forwarding never matches them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush_e) begin
         rd1_e      <= '0;
         rd2_e      <= '0;
         pc_e       <= '0;
         pc_plus4_e <= '0;
         imm_ext_e  <= '0;
         rs1_e      <= '0;
         rs2_e      <= '0;
         rd_e       <= '0;
      end else if (!stall_d) begin
         rd1_e      <= rd1_d;
         rd2_e      <= rd2_d;
         pc_e       <= pc_d;
         pc_plus4_e <= pc_plus4_d;
         imm_ext_e  <= imm_ext_d;
         rs1_e      <= rs1_d;
         rs2_e      <= rs2_d;
         rd_e       <= rd_d;
      end
   end

   assign valid_e       = ctrl_q.valid;
   assign reg_write_e   = ctrl_q.reg_write;
   assign result_src_e  = ctrl_q.result_src;
   assign mem_write_e   = ctrl_q.mem_write;
   assign jump_e        = ctrl_q.jump;
   assign branch_e      = ctrl_q.branch;
   assign alu_control_e = ctrl_q.alu_control;
   assign alu_src_e     = ctrl_q.alu_src;

`ifdef ID_EX_PERF_CNT_EN
   id_ex_perf_cnt #(
      .CNT_W(CNT_W)
   ) u_perf_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall_d   (stall_d),
      .flush_e   (flush_e),
      .bubble_cnt(bubble_cnt),
      .stall_cnt (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg.
// Counter checks compile in with ID_EX_PERF_CNT_EN.
module tb_id_ex_stage_reg;

   localparam logic [1:0] JUMP_JAL = 2'b01;
   localparam logic [2:0] BR_BEQ   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_d, flush_e, valid_d;
   logic        reg_write_d, mem_write_d, alu_src_d;
   logic [1:0]  result_src_d, jump_d;
   logic [2:0]  branch_d, alu_control_d;
   logic [31:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
   logic [4:0]  rs1_d, rs2_d, rd_d;

   logic        valid_e, reg_write_e, mem_write_e, alu_src_e;
   logic [1:0]  result_src_e, jump_e;
   logic [2:0]  branch_e, alu_control_e;
   logic [31:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] bubble_cnt, stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_d      (stall_d),
      .flush_e      (flush_e),
      .valid_d      (valid_d),
      .reg_write_d  (reg_write_d),
      .mem_write_d  (mem_write_d),
      .alu_src_d    (alu_src_d),
      .result_src_d (result_src_d),
      .jump_d       (jump_d),
      .branch_d     (branch_d),
      .alu_control_d(alu_control_d),
      .rd1_d        (rd1_d),
      .rd2_d        (rd2_d),
      .pc_d         (pc_d),
      .pc_plus4_d   (pc_plus4_d),
      .imm_ext_d    (imm_ext_d),
      .rs1_d        (rs1_d),
      .rs2_d        (rs2_d),
      .rd_d         (rd_d),
      .valid_e      (valid_e),
      .reg_write_e  (reg_write_e),
      .mem_write_e  (mem_write_e),
      .alu_src_e    (alu_src_e),
      .result_src_e (result_src_e),
      .jump_e       (jump_e),
      .branch_e     (branch_e),
      .alu_control_e(alu_control_e),
      .rd1_e        (rd1_e),
      .rd2_e        (rd2_e),
      .pc_e         (pc_e),
      .pc_plus4_e   (pc_plus4_e),
      .imm_ext_e    (imm_ext_e),
      .rs1_e        (rs1_e),
      .rs2_e        (rs2_e),
      .rd_e         (rd_e)
`ifdef ID_EX_PERF_CNT_EN
     ,.bubble_cnt   (bubble_cnt)
     ,.stall_cnt    (stall_cnt)
`endif
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic v);
      valid_d       = v;
      reg_write_d   = v;
      mem_write_d   = v;
      alu_src_d     = v;
      result_src_d  = {2{v}};
      jump_d        = {2{v}};
      branch_d      = {3{v}};
      alu_control_d = {3{v}};
      rd1_d         = {32{v}};
      rd2_d         = {32{v}};
      pc_d          = {32{v}};
      pc_plus4_d    = {32{v}};
      imm_ext_d     = {32{v}};
      rs1_d         = {5{v}};
      rs2_d         = {5{v}};
      rd_d          = {5{v}};
   endtask

   initial begin
      rst_n   = 1'b0;
      stall_d = 1'b1;
      flush_e = 1'b1;
      set_all(1'b1);
      tick();
      tick();
      chk("rst_valid", valid_e, 0);
      chk("rst_regw", reg_write_e, 0);
      chk("rst_jump", jump_e, 0);
      chk("rst_rd1", rd1_e, 0);
      chk("rst_pc", pc_e, 0);
      chk("rst_rd", rd_e, 0);
      chk("rst_imm", imm_ext_e, 0);
`ifdef ID_EX_PERF_CNT_EN
      chk("rst_bcnt", bubble_cnt, 0);
      chk("rst_scnt", stall_cnt, 0);
`endif

      // load an add
      stall_d = 1'b0;
      flush_e = 1'b0;
      set_all(1'b0);
      valid_d       = 1'b1;
      reg_write_d   = 1'b1;
      alu_control_d = OP_ADD;
      rd1_d         = 32'd5;
      rd2_d         = 32'd7;
      rd_d          = 5'd3;
      rs1_d         = 5'd1;
      rs2_d         = 5'd2;
      pc_d          = 32'h40;
      pc_plus4_d    = 32'h44;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("add_valid", valid_e, 1);
      chk("add_regw", reg_write_e, 1);
      chk("add_rd1", rd1_e, 5);
      chk("add_rd2", rd2_e, 7);
      chk("add_rd", rd_e, 3);
      chk("add_rs1", rs1_e, 1);
      chk("add_pc4", pc_plus4_e, 32'h44);

      // stall three edges while inputs change
      stall_d     = 1'b1;
      rd1_d       = 32'd99;
      rd_d        = 5'd9;
      reg_write_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_rd1", rd1_e, 5);
         chk("stall_rd", rd_e, 3);
         chk("stall_regw", reg_write_e, 1);
      end
`ifdef ID_EX_PERF_CNT_EN
      chk("stall_scnt", stall_cnt, 3);
      chk("stall_bcnt", bubble_cnt, 0);
`endif

      // flush a store
      stall_d     = 1'b0;
      flush_e     = 1'b1;
      mem_write_d = 1'b1;
      valid_d     = 1'b1;
      tick();
      chk("fl_memw", mem_write_e, 0);
      chk("fl_valid", valid_e, 0);
      chk("fl_rd", rd_e, 0);
      chk("fl_rd1", rd1_e, 0);
`ifdef ID_EX_PERF_CNT_EN
      chk("fl_bcnt", bubble_cnt, 1);
      chk("fl_scnt", stall_cnt, 3);
`endif

      // reload, then stall+flush together
      flush_e = 1'b0;
      tick();
      chk("st_memw", mem_write_e, 1);
      chk("st_rd1", rd1_e, 99);
      stall_d = 1'b1;
      flush_e = 1'b1;
      tick();
      chk("sf_valid", valid_e, 0);
      chk("sf_memw", mem_write_e, 0);
      chk("sf_rd1", rd1_e, 0);
`ifdef ID_EX_PERF_CNT_EN
      chk("sf_bcnt", bubble_cnt, 2);
      chk("sf_scnt", stall_cnt, 3);
`endif

      // invalid slot carrying jal/beq side effects
      stall_d     = 1'b0;
      flush_e     = 1'b0;
      valid_d     = 1'b0;
      jump_d      = JUMP_JAL;
      branch_d    = BR_BEQ;
      reg_write_d = 1'b1;
      mem_write_d = 1'b1;
      rd1_d       = 32'h1234;
      tick();
      chk("inv_jump", jump_e, 0);
      chk("inv_branch", branch_e, 0);
      chk("inv_valid", valid_e, 0);
      chk("inv_regw", reg_write_e, 0);
      chk("inv_memw", mem_write_e, 0);
      chk("inv_rd1", rd1_e, 32'h1234);

      // valid jal passes through
      valid_d      = 1'b1;
      result_src_d = 2'b10;
      alu_src_d    = 1'b1;
      imm_ext_d    = 32'hFFFF_FFF0;
      tick();
      chk("jal_jump", jump_e, JUMP_JAL);
      chk("jal_branch", branch_e, BR_BEQ);
      chk("jal_rsrc", result_src_e, 2'b10);
      chk("jal_asrc", alu_src_e, 1);
      chk("jal_imm", imm_ext_e, 32'hFFFF_FFF0);

      // reset asserted mid-stall clears at once
      stall_d = 1'b1;
      tick();
`ifdef ID_EX_PERF_CNT_EN
      chk("ms_scnt", stall_cnt, 4);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      chk("ms_valid", valid_e, 0);
      chk("ms_jump", jump_e, 0);
      chk("ms_imm", imm_ext_e, 0);
      chk("ms_rd1", rd1_e, 0);
`ifdef ID_EX_PERF_CNT_EN
      chk("ms_scnt0", stall_cnt, 0);
      chk("ms_bcnt0", bubble_cnt, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
